// File: rtl/shift_add_mult4_if.sv
// Handshake/operand bundle for the shift-and-add multiplier.
// The requester drives Start/A/B/Ack; the multiplier returns Busy/Done/P.
interface shift_add_mult4_if #(
    parameter int N = 4
);
    logic           Start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           Ack;
    logic           Busy;
    logic           Done;
    logic [2*N-1:0] P;

    modport master (output Start, A, B, Ack, input Busy, Done, P);
    modport slave  (input Start, A, B, Ack, output Busy, Done, P);
endinterface

// File: rtl/shift_add_mult4.sv
// Sequential unsigned multiplier: one shift-and-add step per clock.
// The step adder is a ripple chain of full adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module shift_add_mult4 #(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_add_mult4_if.slave   bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state, nxt;
    logic [N-1:0]   m, q, acc;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] p_q;

    logic [N-1:0]   addend, sum;
    logic [N:0]     carry;
    logic [N-1:0]   acc_n, q_n;

    assign addend   = q[0] ? m : '0;
    assign carry[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_fa
            full_adder u_fa (
                .a    (acc[i]),
                .b    (addend[i]),
                .cin  (carry[i]),
                .s    (sum[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    // {C,Sum,Q} shifted right by one, split back into Acc and Q
    assign acc_n = {carry[N], sum[N-1:1]};
    assign q_n   = {sum[0], q[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = bus.Start ? CALC : IDLE;
            CALC:    nxt = (cnt == LAST) ? DONE : CALC;
            DONE:    nxt = bus.Ack ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m   <= '0;
            q   <= '0;
            acc <= '0;
            cnt <= '0;
            p_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        m   <= bus.A;
                        q   <= bus.B;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_n;
                    q   <= q_n;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) p_q <= {acc_n, q_n};
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy = (state == CALC);
    assign bus.Done = (state == DONE);
    assign bus.P    = p_q;
endmodule

// File: tb/tb_shift_add_mult4.sv
// Self-checking bench for shift_add_mult4: vector table, corner sequences,
// exhaustive sweep and random operands against a plain a*b model.
module tb_shift_add_mult4;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   last_p = 0;   // model of the value P must hold between results

    shift_add_mult4_if #(.N(4)) bus ();

    shift_add_mult4 #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         p;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply and wait for Done; latency counted from the accepting edge.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int exp,
                          input bit do_ack);
        int lat;
        int nbusy;
        int p_moved;
        bus.A = a;
        bus.B = b;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        lat = 0;
        nbusy = 0;
        p_moved = 0;
        while (!bus.Done && lat < 20) begin
            if (bus.Busy) nbusy++;
            if (int'(bus.P) != last_p) p_moved++;
            bus.A = 4'($urandom);
            bus.B = 4'($urandom);
            step();
            lat++;
        end
        chk("latency", lat, 4);
        chk("busy_cycles", nbusy, 4);
        chk("p_held_in_calc", p_moved, 0);
        chk("product", int'(bus.P), exp);
        last_p = exp;
        if (do_ack) begin
            bus.Ack = 1'b1;
            step();
            bus.Ack = 1'b0;
            chk("done_falls_on_ack", int'(bus.Done), 0);
        end
    endtask

    initial begin
        vec_t vt[6];
        int   lat;
        int   nbusy;

        vt[0] = '{a: 4'd15, b: 4'd15, p: 225};
        vt[1] = '{a: 4'd9,  b: 4'd6,  p: 54};
        vt[2] = '{a: 4'd0,  b: 4'd7,  p: 0};
        vt[3] = '{a: 4'd1,  b: 4'd1,  p: 1};
        vt[4] = '{a: 4'd8,  b: 4'd0,  p: 0};
        vt[5] = '{a: 4'd10, b: 4'd11, p: 110};

        rst_n = 1'b0;
        bus.Start = 1'b0;
        bus.Ack = 1'b0;
        bus.A = '0;
        bus.B = '0;
        step();
        step();
        chk("reset_busy", int'(bus.Busy), 0);
        chk("reset_done", int'(bus.Done), 0);
        chk("reset_p", int'(bus.P), 0);
        rst_n = 1'b1;
        step();

        // First vector: Done must hold with P stable until Ack
        run_op(vt[0].a, vt[0].b, vt[0].p, 1'b0);
        repeat (3) begin
            step();
            chk("done_hold", int'(bus.Done), 1);
            chk("p_hold", int'(bus.P), 225);
        end
        bus.Ack = 1'b1;
        step();
        bus.Ack = 1'b0;
        chk("done_after_ack", int'(bus.Done), 0);
        chk("p_in_idle", int'(bus.P), 225);

        for (int i = 1; i < 6; i++) run_op(vt[i].a, vt[i].b, vt[i].p, 1'b1);

        // Start held through CALC with different operands: no restart
        bus.A = 4'd5;
        bus.B = 4'd5;
        bus.Start = 1'b1;
        step();
        bus.A = 4'd3;
        bus.B = 4'd3;
        lat = 0;
        nbusy = 0;
        while (!bus.Done && lat < 20) begin
            if (bus.Busy) nbusy++;
            step();
            lat++;
        end
        chk("held_start_latency", lat, 4);
        chk("held_start_busy", nbusy, 4);
        chk("held_start_p", int'(bus.P), 25);
        step();
        chk("start_ignored_in_done", int'(bus.Done), 1);
        bus.Start = 1'b0;
        bus.Ack = 1'b1;
        step();
        bus.Ack = 1'b0;
        last_p = 25;

        // Async reset in the 2nd CALC cycle of 12*13
        bus.A = 4'd12;
        bus.B = 4'd13;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        step();
        chk("busy_before_reset", int'(bus.Busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(bus.Busy), 0);
        chk("async_rst_done", int'(bus.Done), 0);
        chk("async_rst_p", int'(bus.P), 0);
        #1 rst_n = 1'b1;
        last_p = 0;
        step();
        chk("no_partial_after_reset", int'(bus.Done) + int'(bus.Busy), 0);
        run_op(4'd2, 4'd3, 6, 1'b1);

        // Start and Ack together in DONE: back to IDLE only
        run_op(4'd4, 4'd4, 16, 1'b0);
        bus.Start = 1'b1;
        bus.Ack = 1'b1;
        bus.A = 4'd9;
        bus.B = 4'd9;
        step();
        bus.Start = 1'b0;
        chk("start_ack_done", int'(bus.Done), 0);
        chk("start_ack_busy", int'(bus.Busy), 0);
        step();
        chk("start_ack_no_op", int'(bus.Busy), 0);
        chk("ack_in_idle_busy", int'(bus.Busy), 0);
        step();
        bus.Ack = 1'b0;
        chk("ack_in_idle_done", int'(bus.Done), 0);
        chk("ack_in_idle_p", int'(bus.P), 16);
        run_op(4'd7, 4'd8, 56, 1'b1);

        // Exhaustive sweep against the a*b model
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op(4'(a), 4'(b), a * b, 1'b1);

        // Random operands with random idle gaps
        for (int k = 0; k < 40; k++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = 4'($urandom);
            rb = 4'($urandom);
            repeat ($urandom_range(0, 2)) step();
            run_op(ra, rb, int'(ra) * int'(rb), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_add_mult4.md
SHIFT_ADD_MULT4 -- requirements
Module: shift_add_mult4

Interface
REQ-001 Parameter N, default 4, operand width; only N=4 is supported and verified.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 A  input  N  multiplicand; captured on the accepted Start edge.
REQ-006 B  input  N  multiplier; captured on the accepted Start edge.
REQ-007 Ack  input  1  consumer acknowledge of the result; sampled only in DONE.
REQ-008 Busy  output  1  high while in CALC.
REQ-009 Done  output  1  high while in DONE; the result on P is valid.
REQ-010 P  output  2N  unsigned product A*B, registered.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC and DONE, encoded in two bits.
REQ-012 IDLE with Start=1 at an edge SHALL load M=A, Q=B, Acc=0, Cnt=0 and go to CALC; with Start=0 it stays in IDLE.
REQ-013 Each CALC edge SHALL compute {C,Sum} = Acc + (Q[0] ? M : 0) and load {Acc,Q} <= {C,Sum,Q} >> 1; it also SHALL set Cnt <= Cnt+1.
REQ-014 The N-bit adder SHALL be a ripple chain of N full_adder instances with carry-in 0; C is the final Cout.
REQ-015 On the CALC edge where Cnt==N-1, the block SHALL load P <= the shifted {Acc,Q} and go to DONE.
REQ-016 Latency SHALL be exactly N edges (4) from the accepting edge to Done=1; Busy SHALL be high for exactly N cycles.
REQ-017 DONE SHALL hold Done=1 and P stable until an edge with Ack=1, then go to IDLE; Done falls on that edge.
REQ-018 Start outside IDLE SHALL be ignored: no reload, and operands are unaffected.
REQ-019 Ack outside DONE SHALL be ignored.
REQ-020 In DONE with Start=1 and Ack=1 on the same edge, the block SHALL go to IDLE only; that Start is not accepted, so a new Start is needed in IDLE.
REQ-021 P SHALL hold its last result through IDLE and CALC, and change only on DONE entry.
REQ-022 A and B changing during CALC or DONE SHALL NOT affect the result.
REQ-023 Arithmetic is unsigned; the maximum product is 15*15 = 225 (0xE1), and there is no overflow in 2N bits.
REQ-024 Cnt SHALL be ceil(log2(N)) bits wide and SHALL NOT wrap within one operation.
REQ-025 Unused or illegal state encoding SHALL return to IDLE on the next edge, with outputs as in IDLE.

Reset
REQ-026 rst_n=0 SHALL, without waiting for clk, force state IDLE and clear Busy, Done, P, M, Q, Acc and Cnt to 0.
REQ-027 Reset asserted mid-CALC or in DONE SHALL abandon the operation; no partial result appears on P.
REQ-028 After rst_n rises, the first Start SHALL be accepted at the first rising clk edge where it is high.

Verification
REQ-029 Reset, then A=15, B=15, Start pulse -> Busy=1 for 4 cycles; Done=1 on the 4th edge; P=0xE1; Done holds until Ack.
REQ-030 A=9, B=6 -> P=54 (0x36); A=0, B=7 -> P=0; A=1, B=1 -> P=1; each has 4-cycle latency.
REQ-031 Start=1 held continuously during CALC with A=3, B=3, original A=5, B=5 -> P=25; no restart, and Busy stays exactly 4 cycles.
REQ-032 rst_n pulsed low at the 2nd CALC cycle of 12*13 -> Busy=0, Done=0 and P=0 immediately (asynchronously); the next Start with 2*3 -> P=6.
REQ-033 In DONE, Start and Ack high together -> IDLE, no new operation; a later Start with 7*8 -> P=56. Ack high in IDLE has no effect.
REQ-034 Exhaustive 256-pair sweep with Ack on the cycle after Done -> every P equals A*B, with latency 4 each time.
